// File: rtl/lcd_pkg.sv
// Shared LCD pixel-pipeline definitions: dither selector width and the
// nibble rotate used to build position hashes.
package lcd_pkg;

  localparam int GS_SEL_W = 4;

  // Rotate a nibble left; amount 1 maps {b3,b2,b1,b0} to {b2,b1,b0,b3}.
  function automatic logic [GS_SEL_W-1:0] rotl4(input logic [GS_SEL_W-1:0] value,
                                                input logic [1:0]          amount);
    logic [2*GS_SEL_W-1:0] w_dbl;
    w_dbl = {value, value} << amount;
    return w_dbl[2*GS_SEL_W-1:GS_SEL_W];
  endfunction

endpackage

// File: rtl/gs_xor_if.sv
// Position-in / selector-out bundle between the pixel counters and the
// grey-scale dither selector.
interface gs_xor_if
  import lcd_pkg::*;
#(
  parameter int CNT_W = 20
);
  logic [CNT_W-1:0]    gscnt;
  logic [GS_SEL_W-1:0] xv_r;

  modport master (output gscnt, input  xv_r);
  modport slave  (input  gscnt, output xv_r);
endinterface

// File: rtl/gs_xor.sv
// Grey-scale dither pattern selector: XOR-folds the pixel position into a
// 4-bit permutation index, registered once.
module gs_xor
  import lcd_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int OUT_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  gs_xor_if.slave  bus
);

  localparam int NIB   = (CNT_W + 3) / 4;
  localparam int PAD_W = NIB * 4;

  if (OUT_W != GS_SEL_W) begin : g_bad_out_w
    $error("gs_xor: OUT_W must be %0d", GS_SEL_W);
  end
  if (CNT_W < 4) begin : g_bad_cnt_w
    $error("gs_xor: CNT_W must be at least 4");
  end

  logic [PAD_W-1:0]    w_padded;
  logic [GS_SEL_W-1:0] w_fold [NIB+1];
  logic [GS_SEL_W-1:0] r_xv;

  assign w_padded  = PAD_W'(bus.gscnt);
  assign w_fold[0] = '0;

  // Nibble k is rotated by k mod 4 so that equal bits in different nibbles
  // land on different selector bits instead of cancelling.
  for (genvar k = 0; k < NIB; k++) begin : g_nib
    assign w_fold[k+1] = w_fold[k] ^ rotl4(w_padded[4*k +: 4], 2'(k % 4));
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every flop
    // samples the pre-edge value regardless of block evaluation order.
    if (rst) r_xv <= '0;
    else     r_xv <= w_fold[NIB];
  end

  assign bus.xv_r = r_xv;

endmodule

// File: tb/tb_gs_xor.sv
// Scoreboard bench for gs_xor: driver pushes expected selector values, a
// monitor pops and compares one cycle later.
module tb_gs_xor;
  import lcd_pkg::*;

  localparam int CNT_W = 20;

  typedef struct {
    logic [3:0] exp;
    int         tag;   // 0 plain, 1 = xv(a), 2 = xv(b), 3 = xv(a^b)
    string      name;
  } sb_entry_t;

  logic clk;
  logic rst;
  gs_xor_if #(.CNT_W(CNT_W)) bus ();

  gs_xor #(.CNT_W(CNT_W), .OUT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sb_entry_t  sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [15:0] seen    = '0;
  logic [3:0] obs_a, obs_b;
  bit         stim_done = 0;

  // Independent bitwise reference: bit i of the position lands on selector
  // bit (i + i/4) mod 4.
  function automatic logic [3:0] ref_xv(input logic [CNT_W-1:0] v);
    logic [3:0] res;
    res = '0;
    for (int i = 0; i < CNT_W; i++)
      if (v[i]) res[(i % 4 + (i / 4) % 4) % 4] ^= 1'b1;
    return res;
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what xv_r must show after the edge.
  task automatic drive(input logic r, input logic [CNT_W-1:0] v,
                       input logic [3:0] exp, input int tag, input string nm);
    sb_entry_t e;
    @(negedge clk);
    #1;
    rst       = r;
    bus.gscnt = v;
    e.exp  = r ? 4'h0 : exp;
    e.tag  = tag;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: every negedge, the entry pushed in the previous cycle is due.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, bus.xv_r, e.exp);
        if (!$isunknown(bus.xv_r)) seen[bus.xv_r] = 1'b1;
        else check({e.name, "_known"}, 4'hX, e.exp);
        if (e.tag == 1) obs_a = bus.xv_r;
        if (e.tag == 2) obs_b = bus.xv_r;
        if (e.tag == 3) check("linearity", bus.xv_r, obs_a ^ obs_b);
      end
    end
  end

  initial begin
    logic [CNT_W-1:0] a, b;
    rst       = 1'b1;
    bus.gscnt = 20'hFFFFF;

    drive(1'b1, 20'hFFFFF, 4'h0, 0, "reset0");
    drive(1'b1, 20'hFFFFF, 4'h0, 0, "reset1");
    drive(1'b0, 20'hFFFFF, 4'hF, 0, "after_reset");

    drive(1'b0, 20'h00001, 4'h1, 0, "walk_b0");
    drive(1'b0, 20'h00010, 4'h2, 0, "walk_b4");
    drive(1'b0, 20'h00100, 4'h4, 0, "walk_b8");
    drive(1'b0, 20'h01000, 4'h8, 0, "walk_b12");
    drive(1'b0, 20'h10000, 4'h1, 0, "walk_b16");
    drive(1'b0, 20'h00400, 4'h1, 0, "vcnt1");
    drive(1'b0, 20'h12345, 4'h1, 0, "mixed");
    drive(1'b0, 20'h00000, 4'h0, 0, "zero");

    drive(1'b0, 20'h00001, 4'h1, 0, "pipe0");
    drive(1'b0, 20'h00010, 4'h2, 0, "pipe1");
    drive(1'b0, 20'h00100, 4'h4, 0, "pipe2");

    drive(1'b0, 20'h01000, 4'h8, 0, "pre_mid_rst");
    drive(1'b1, 20'h01000, 4'h0, 0, "mid_rst");
    drive(1'b0, 20'h01000, 4'h8, 0, "post_mid_rst");

    for (int i = 0; i < 1000; i++) begin
      a = CNT_W'($urandom);
      b = CNT_W'($urandom);
      drive(1'b0, a,     ref_xv(a),     1, "rand_a");
      drive(1'b0, b,     ref_xv(b),     2, "rand_b");
      drive(1'b0, a ^ b, ref_xv(a ^ b), 3, "rand_axb");
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    check("all_values_seen", 4'(seen != 16'hFFFF), 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
